io_mmio_controller: RTL and testbench
=====================================

Name: io_mmio_controller

Overview:
- Parametrised memory-mapped IO peripheral that replaces the fixed board-IO path behind the data-memory decoder.
- Provides debounced buttons with sticky event flags, synchronised switches, and a multiplexed N-digit hex 7-segment display with per-digit decimal points.
- The MIPS core reaches it through word-addressed loads and stores; an external decoder drives `sel`.

Parameters:
- NUM_DIGITS, 8, number of 7-seg digits (1..8); DISPLAY holds NUM_DIGITS nibbles, digit 0 = bits [3:0].
- SW_WIDTH, 16, switch count (1..32).
- NUM_BTN, 2, button count (1..16).
- DEBOUNCE_CYCLES, 1000000, cycles the input must be stable before acceptance (>=2).
- REFRESH_DIV, 100000, clock cycles each digit is displayed (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- sel  in  1  peripheral selected by the address decoder
- we  in  1  write enable; effective only when sel=1
- adr  in  5  byte offset; adr[4:2] = word index, adr[1:0] ignored
- wd  in  32  write data
- rd  out  32  read data (combinational from registers)
- btn  in  NUM_BTN  raw buttons, asynchronous
- sw  in  SW_WIDTH  raw switches, asynchronous
- an  out  NUM_DIGITS  digit enables, active-low
- a2g  out  7  segments {a..g}, active-low
- dp  out  1  decimal point, active-low
- irq  out  1  level interrupt (see Optional Feature)

Behaviour:
- Register map (word index):
  - 0 STATUS: pending button events; read gives pending in low bits; write-1-to-clear.
  - 1 SWITCH: read-only, synchronised switches, zero-extended.
  - 2 DISPLAY: read/write, low NUM_DIGITS*4 bits; upper bits read 0.
  - 3 DPMASK: read/write, low NUM_DIGITS bits; bit i=1 lights the DP of digit i.
  - 4 IRQMASK: see Optional Feature.
  - 5..7: read 0, writes ignored.
- Write timing: register updates at the clk edge where sel&we; new value is visible on rd the following cycle.
- rd = 0 when sel=0.
- Synchronisers: btn and sw each pass through 2 flops. A SWITCH read reflects a sw change 2 cycles later.
- Debounce, per button:
  - State: stable bit plus counter.
  - If synchronised != stable, counter increments; otherwise counter clears.
  - When counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present: stable takes the new value and counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Events: a stable 0->1 transition sets pending[i].
  - Pending is sticky until cleared by a STATUS write with bit i=1.
  - If a set and a clear land in the same cycle, set wins.
  - Release (1->0) sets nothing.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1; at its terminal count, idx advances.
  - idx wraps from NUM_DIGITS-1 to 0.
  - With NUM_DIGITS=1, idx stays 0.
- Display outputs: an, a2g and dp are registered and lag idx by 1 cycle.
  - an = ~(1<<idx).
  - a2g = active-low standard hex decode of DISPLAY nibble idx (0-9, A, b, C, d, E, F). Examples: 0 -> 7'b0000001, 8 -> 7'b0000000, F -> 7'b0111000 (order a..g, MSB = a).
  - dp = ~DPMASK[idx].
- Reset values:
  - STATUS, DISPLAY, DPMASK, IRQMASK, pending, stable, debounce counters, synchronisers, prescaler and idx: all 0.
  - an all 1s, a2g 7'h7F, dp 1, irq 0.
  - First digit is driven the cycle after reset deasserts.
- Reset mid-operation: all state returns to reset values at that edge; any in-flight debounce is discarded.
  - A button held through reset produces an event once stable rises after reset, i.e. after DEBOUNCE_CYCLES plus synchroniser latency.
- DISPLAY change mid-scan: takes effect on the next registered output update with no tearing beyond 1 cycle.

Optional Feature:
- Macro IO_MMIO_IRQ_EN.
- Defined:
  - IRQMASK (word 4) is read/write, low NUM_BTN bits, reset 0.
  - irq is registered: irq = |(pending & IRQMASK), asserted 1 cycle after the causing pending set or mask write.
  - irq deasserts 1 cycle after the clearing write.
- Undefined:
  - irq tied 0.
  - Word 4 reads 0 and writes are ignored.
  - No mask flops are synthesised.

Test Plan:
- Params NUM_DIGITS=4, DEBOUNCE_CYCLES=4, REFRESH_DIV=2:
  - After reset: an=4'hF, a2g=7'h7F, dp=1, rd=0.
  - Then an cycles E, D, B, 7, E, advancing every 2 cycles.
- DISPLAY write 32'h0000_A3F0 with DPMASK=4'b0100:
  - Digit 0 a2g=7'b0000001, digit 1 7'b0111000, digit 2 7'b0000110 with dp=0, digit 3 7'b0001000.
  - Read DISPLAY gives 32'h0000_A3F0.
- btn[0] pulsed high for 3 cycles:
  - No pending bit.
  - Held 10 cycles: STATUS reads 1 after 2+4 cycles.
  - Write STATUS=1: STATUS reads 0.
- Set/clear collision: stable edge on btn[1] in the same cycle as a STATUS write of 2 -> pending[1] stays 1.
- sw=16'hBEEF: SWITCH reads 32'h0000_BEEF on the 3rd cycle after the change. Writes to words 1 and 5 have no effect.
- IO_MMIO_IRQ_EN defined:
  - IRQMASK=1 and btn[0] event -> irq=1.
  - Write IRQMASK=0 -> irq=0 the next cycle.
  - Without the macro, irq stays 0 throughout.

Source files
------------

// File: rtl/io_mmio_controller.sv
// Memory-mapped board IO: debounced buttons with sticky events, synchronised switches and a
// multiplexed hex 7-segment display. Define IO_MMIO_IRQ_EN to add IRQMASK and the irq output.
module io_mmio_controller #(
    parameter int unsigned NUM_DIGITS      = 8,
    parameter int unsigned SW_WIDTH        = 16,
    parameter int unsigned NUM_BTN         = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned REFRESH_DIV     = 100000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sel,
    input  logic                  we,
    input  logic [4:0]            adr,
    input  logic [31:0]           wd,
    output logic [31:0]           rd,
    input  logic [NUM_BTN-1:0]    btn,
    input  logic [SW_WIDTH-1:0]   sw,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            a2g,
    output logic                  dp,
    output logic                  irq
);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned PS_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DISP_W = NUM_DIGITS * 4;

    localparam logic [DB_W-1:0]       DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PS_W-1:0]       PS_LAST = PS_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIG_ONE = NUM_DIGITS'(1);

    logic [2:0] word;
    logic       wr_en;

    logic [NUM_BTN-1:0]    btn_meta, btn_sync;
    logic [SW_WIDTH-1:0]   sw_meta, sw_sync;
    logic [NUM_BTN-1:0]    stable_q, stable_d, rise;
    logic [DB_W-1:0]       db_cnt_q [NUM_BTN];
    logic [DB_W-1:0]       db_cnt_d [NUM_BTN];
    logic [NUM_BTN-1:0]    pending_q, pending_d, clr;
    logic [DISP_W-1:0]     display_q;
    logic [NUM_DIGITS-1:0] dpmask_q;
    logic [PS_W-1:0]       presc_q;
    logic [IDX_W-1:0]      idx_q;
    logic [3:0]            cur_nibble;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            a2g_q;
    logic                  dp_q;
`ifdef IO_MMIO_IRQ_EN
    logic [NUM_BTN-1:0]    irqmask_q;
    logic                  irq_q;
`endif

    // Byte-lane bits of adr and unmapped wd bits are intentionally ignored.
    logic unused;
    assign unused = ^{adr[1:0], wd};

    assign word  = adr[4:2];
    assign wr_en = sel & we;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h7F;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatching samples.
    always_comb begin
        stable_d = stable_q;
        rise     = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            db_cnt_d[i] = '0;
            if (btn_sync[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = btn_sync[i];
                    rise[i]     = btn_sync[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end
    end

    // A new event in the same cycle as its clear survives.
    assign clr        = (wr_en && word == 3'd0) ? wd[NUM_BTN-1:0] : '0;
    assign pending_d  = (pending_q & ~clr) | rise;
    assign cur_nibble = 4'(display_q >> {idx_q, 2'b00});

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta  <= '0;
            btn_sync  <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            stable_q  <= '0;
            db_cnt_q  <= '{default: '0};
            pending_q <= '0;
            display_q <= '0;
            dpmask_q  <= '0;
            presc_q   <= '0;
            idx_q     <= '0;
            an_q      <= '1;
            a2g_q     <= 7'h7F;
            dp_q      <= 1'b1;
        end else begin
            btn_meta  <= btn;
            btn_sync  <= btn_meta;
            sw_meta   <= sw;
            sw_sync   <= sw_meta;
            stable_q  <= stable_d;
            db_cnt_q  <= db_cnt_d;
            pending_q <= pending_d;
            if (wr_en && word == 3'd2) display_q <= wd[DISP_W-1:0];
            if (wr_en && word == 3'd3) dpmask_q <= wd[NUM_DIGITS-1:0];
            if (presc_q == PS_LAST) begin
                presc_q <= '0;
                idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                presc_q <= presc_q + PS_W'(1);
            end
            an_q  <= ~(DIG_ONE << idx_q);
            a2g_q <= hex_seg(cur_nibble);
            dp_q  <= ~dpmask_q[idx_q];
        end
    end

`ifdef IO_MMIO_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irqmask_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (wr_en && word == 3'd4) irqmask_q <= wd[NUM_BTN-1:0];
            irq_q <= |(pending_q & irqmask_q);
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        rd = '0;
        if (sel) begin
            case (word)
                3'd0: rd = 32'(pending_q);
                3'd1: rd = 32'(sw_sync);
                3'd2: rd = 32'(display_q);
                3'd3: rd = 32'(dpmask_q);
`ifdef IO_MMIO_IRQ_EN
                3'd4: rd = 32'(irqmask_q);
`endif
                default: rd = '0;
            endcase
        end
    end

    assign an  = an_q;
    assign a2g = a2g_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_io_mmio_controller.sv
// Bench for io_mmio_controller: cycle-level behavioural model plus directed literal checks.
module tb_io_mmio_controller;
    localparam int ND  = 4;
    localparam int SWW = 16;
    localparam int NB  = 2;
    localparam int DB  = 4;
    localparam int RFD = 2;

    logic        clk = 1'b0;
    logic        reset, sel, we;
    logic [4:0]  adr;
    logic [31:0] wd, rd;
    logic [1:0]  btn;
    logic [15:0] sw;
    logic [3:0]  an;
    logic [6:0]  a2g;
    logic        dp, irq;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    io_mmio_controller #(
        .NUM_DIGITS     (ND),
        .SW_WIDTH       (SWW),
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DB),
        .REFRESH_DIV    (RFD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sel  (sel),
        .we   (we),
        .adr  (adr),
        .wd   (wd),
        .rd   (rd),
        .btn  (btn),
        .sw   (sw),
        .an   (an),
        .a2g  (a2g),
        .dp   (dp),
        .irq  (irq)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        return t[v];
    endfunction

    // Model state: values as seen after the most recent clock edge.
    logic        m_valid = 1'b0;
    int          m_k;
    int          m_run [2];
    int          m_d;
    logic [1:0]  m_bh0, m_bh1, m_stable, m_pend, m_irqm, m_rise, m_clr;
    logic [15:0] m_sh0, m_sh1, m_disp;
    logic [3:0]  m_dpm, e_an;
    logic [6:0]  e_a2g;
    logic        e_dp, e_irq, m_irq_next;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid = 1'b1;
                m_k = 0;
                m_run[0] = 0;
                m_run[1] = 0;
                {m_bh0, m_bh1, m_stable, m_pend, m_irqm} = '0;
                {m_sh0, m_sh1, m_disp} = '0;
                m_dpm = '0;
                e_an = 4'hF;
                e_a2g = 7'h7F;
                e_dp = 1'b1;
                e_irq = 1'b0;
            end else begin
                // Digit shown after edge k was selected by the scan position before it.
                m_d   = (m_k / RFD) % ND;
                e_an  = ~(4'b0001 << m_d);
                e_a2g = seg_of(m_disp[m_d*4 +: 4]);
                e_dp  = ~m_dpm[m_d];
                m_k++;
`ifdef IO_MMIO_IRQ_EN
                m_irq_next = |(m_pend & m_irqm);
`else
                m_irq_next = 1'b0;
`endif
                m_rise = '0;
                for (int i = 0; i < NB; i++) begin
                    if (m_bh1[i] != m_stable[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_stable[i] = m_bh1[i];
                            m_run[i] = 0;
                            m_rise[i] = m_stable[i];
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_clr = (sel && we && adr[4:2] == 3'd0) ? wd[1:0] : 2'b00;
                m_pend = (m_pend & ~m_clr) | m_rise;
                if (sel && we && adr[4:2] == 3'd2) m_disp = wd[15:0];
                if (sel && we && adr[4:2] == 3'd3) m_dpm = wd[3:0];
`ifdef IO_MMIO_IRQ_EN
                if (sel && we && adr[4:2] == 3'd4) m_irqm = wd[1:0];
`endif
                m_bh1 = m_bh0;
                m_bh0 = btn;
                m_sh1 = m_sh0;
                m_sh0 = sw;
                e_irq = m_irq_next;
            end
        end
    end

    function automatic logic [31:0] exp_rd();
        if (!sel) return 32'h0;
        case (adr[4:2])
            3'd0: return 32'(m_pend);
            3'd1: return 32'(m_sh1);
            3'd2: return 32'(m_disp);
            3'd3: return 32'(m_dpm);
`ifdef IO_MMIO_IRQ_EN
            3'd4: return 32'(m_irqm);
`endif
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (m_valid) begin
                check("model_an", 32'(an), 32'(e_an));
                check("model_a2g", 32'(a2g), 32'(e_a2g));
                check("model_dp", 32'(dp), 32'(e_dp));
                check("model_irq", 32'(irq), 32'(e_irq));
                check("model_rd", rd, exp_rd());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input int word, input logic [31:0] data);
        sel = 1'b1;
        we  = 1'b1;
        adr = 5'(word << 2);
        wd  = data;
        @(negedge clk);
        sel = 1'b0;
        we  = 1'b0;
        wd  = 32'h0;
    endtask

    task automatic rd_check(input string name, input int word, input logic [31:0] exp);
        sel = 1'b1;
        we  = 1'b0;
        adr = 5'(word << 2);
        #1;
        check(name, rd, exp);
        @(negedge clk);
        sel = 1'b0;
    endtask

    logic [3:0] scan_seq [5];

    initial begin
        scan_seq = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        reset = 1'b1;
        sel = 1'b0;
        we = 1'b0;
        adr = '0;
        wd = '0;
        btn = '0;
        sw = '0;
        step(3);
        check("rst_an", 32'(an), 32'hF);
        check("rst_a2g", 32'(a2g), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_rd", rd, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step(1);
            check("scan_an", 32'(an), 32'(scan_seq[i]));
            step(1);
        end

        wr(2, 32'h0000_A3F0);
        wr(3, 32'h4);
        step(2);
        for (int i = 0; i < 8; i++) begin
            case (an)
                4'hE: begin
                    check("dig0_a2g", 32'(a2g), 32'(7'b0000001));
                    check("dig0_dp", 32'(dp), 32'h1);
                end
                4'hD: begin
                    check("dig1_a2g", 32'(a2g), 32'(7'b0111000));
                    check("dig1_dp", 32'(dp), 32'h1);
                end
                4'hB: begin
                    check("dig2_a2g", 32'(a2g), 32'(7'b0000110));
                    check("dig2_dp", 32'(dp), 32'h0);
                end
                4'h7: begin
                    check("dig3_a2g", 32'(a2g), 32'(7'b0001000));
                    check("dig3_dp", 32'(dp), 32'h1);
                end
                default: check("an_onehot", 32'(an), 32'hE);
            endcase
            step(1);
        end
        rd_check("display_rd", 2, 32'h0000_A3F0);
        rd_check("dpmask_rd", 3, 32'h4);

        // Short glitch must not register.
        btn = 2'b01;
        step(3);
        btn = 2'b00;
        step(10);
        rd_check("glitch_status", 0, 32'h0);

        // Held press: event visible 2 sync + 4 debounce edges later.
        btn = 2'b01;
        sel = 1'b1;
        adr = 5'd0;
        step(5);
        #1 check("status_early", rd, 32'h0);
        step(1);
        #1 check("status_set", rd, 32'h1);
        sel = 1'b0;
        step(6);
        btn = 2'b00;
        step(10);
        rd_check("release_no_event", 0, 32'h1);
        wr(0, 32'h1);
        rd_check("status_clr", 0, 32'h0);

        // Clear lands on the same edge that sets pending[1].
        btn = 2'b10;
        step(5);
        wr(0, 32'h2);
        rd_check("collide_set_wins", 0, 32'h2);
        btn = 2'b00;
        step(10);
        wr(0, 32'h3);
        rd_check("collide_clr", 0, 32'h0);

        sw = 16'hBEEF;
        sel = 1'b1;
        adr = 5'd4;
        step(1);
        #1 check("sw_lat1", rd, 32'h0);
        step(1);
        #1 check("sw_lat2", rd, 32'h0000_BEEF);
        sel = 1'b0;
        step(1);
        wr(1, 32'h1234);
        wr(5, 32'hFFFF_FFFF);
        rd_check("sw_readonly", 1, 32'h0000_BEEF);
        rd_check("word5_zero", 5, 32'h0);

`ifdef IO_MMIO_IRQ_EN
        wr(4, 32'h1);
        btn = 2'b01;
        step(6);
        #1 check("irq_pre", 32'(irq), 32'h0);
        step(1);
        #1 check("irq_set", 32'(irq), 32'h1);
        wr(4, 32'h0);
        #1 check("irq_hold", 32'(irq), 32'h1);
        step(1);
        #1 check("irq_clear", 32'(irq), 32'h0);
        rd_check("irqmask_rd0", 4, 32'h0);
        wr(4, 32'h3);
        rd_check("irqmask_rd3", 4, 32'h3);
        wr(4, 32'h0);
`else
        wr(4, 32'hFFFF);
        btn = 2'b01;
        step(8);
        check("irq_tied", 32'(irq), 32'h0);
        rd_check("word4_zero", 4, 32'h0);
`endif
        btn = 2'b00;
        step(10);
        wr(0, 32'h3);

        // Reset mid-debounce with the button held through it.
        btn = 2'b01;
        step(3);
        reset = 1'b1;
        step(1);
        check("midrst_an", 32'(an), 32'hF);
        check("midrst_a2g", 32'(a2g), 32'h7F);
        reset = 1'b0;
        sel = 1'b1;
        adr = 5'd0;
        step(5);
        #1 check("midrst_early", rd, 32'h0);
        step(1);
        #1 check("midrst_event", rd, 32'h1);
        sel = 1'b0;
        rd_check("disp_after_rst", 2, 32'h0);
        step(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
